// File: rtl/id_ex_issue_ctrl_pkg.sv
// Shared definitions for the ID/EX issue controller: opcode classes,
// forwarding-select encodings, controller states and the per-opcode
// class record produced by the opcode decoder.
package id_ex_issue_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE_LO = 6'b000001;
   localparam logic [5:0] OP_RTYPE_HI = 6'b001000;
   localparam logic [5:0] OP_IMM_LO   = 6'b001001;
   localparam logic [5:0] OP_IMM_HI   = 6'b001011;
   localparam logic [5:0] OP_LW       = 6'b001100;
   localparam logic [5:0] OP_SW       = 6'b001101;
   localparam logic [5:0] OP_HLT      = 6'b111111;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwdSel_t;

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      DRAIN  = 2'b01,
      HALTED = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      DEST_NONE = 2'b00,
      DEST_RT   = 2'b01,
      DEST_RD   = 2'b10
   } destSel_t;

   typedef struct packed {
      logic     usesRs;
      logic     usesRt;
      destSel_t destSel;
      logic     isLoad;
      logic     isHalt;
   } opClass_t;

   // Picks the forwarding source for one operand; the youngest producer
   // (EX slot) wins over the MEM slot, and r0 or an unused operand never
   // forwards.
   function automatic fwdSel_t fwdSelect(
      input logic       used,
      input logic [4:0] src,
      input logic       exValid,
      input logic [4:0] exDest,
      input logic       memValid,
      input logic [4:0] memDest
   );
      fwdSel_t sel;
      sel = FWD_RF;
      if (used && (src != 5'd0)) begin
         if (exValid && (exDest == src)) begin
            sel = FWD_EXMEM;
         end else if (memValid && (memDest == src)) begin
            sel = FWD_MEMWB;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/id_ex_issue_ctrl_op_class_decode.sv
// Combinational opcode classifier: which register fields an instruction
// reads, where its destination comes from, and whether it is a load or halt.
module op_class_decode
   import id_ex_issue_ctrl_pkg::*;
(
   input  logic [5:0] i_opcode,
   output opClass_t   o_class
);

   // Map the opcode onto its class; unknown opcodes read and write nothing.
   always_comb begin
      o_class = '0;
      if ((i_opcode >= OP_RTYPE_LO) && (i_opcode <= OP_RTYPE_HI)) begin
         o_class.usesRs  = 1'b1;
         o_class.usesRt  = 1'b1;
         o_class.destSel = DEST_RD;
      end else if ((i_opcode >= OP_IMM_LO) && (i_opcode <= OP_IMM_HI)) begin
         o_class.usesRs  = 1'b1;
         o_class.destSel = DEST_RT;
      end else if (i_opcode == OP_LW) begin
         o_class.usesRs  = 1'b1;
         o_class.destSel = DEST_RT;
         o_class.isLoad  = 1'b1;
      end else if (i_opcode == OP_SW) begin
         o_class.usesRs  = 1'b1;
         o_class.usesRt  = 1'b1;
      end else if (i_opcode == OP_HLT) begin
         o_class.isHalt  = 1'b1;
      end
   end

endmodule

// File: rtl/id_ex_issue_ctrl.sv
// ID-to-EX issue controller: load-use stall/bubble insertion, registered
// forwarding selects, in-flight destination tracking and halt-and-drain.
module id_ex_issue_ctrl
   import id_ex_issue_ctrl_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_idValid,
   input  logic [5:0] i_idOpcode,
   input  logic [4:0] i_idRs,
   input  logic [4:0] i_idRt,
   input  logic [4:0] i_idRd,
   input  logic       i_exReady,
   input  logic       i_flush,
   output logic       o_idStall,
   output logic       o_exValid,
   output logic [5:0] o_exOpcode,
   output logic [4:0] o_exDest,
   output logic [1:0] o_fwdASel,
   output logic [1:0] o_fwdBSel,
   output logic       o_halted
);

   opClass_t   w_cls;
   logic [4:0] w_idDest;
   logic       w_rsHitLoad;
   logic       w_rtHitLoad;
   logic       w_loadUse;
   logic       w_issue;
   fwdSel_t    w_fwdA;
   fwdSel_t    w_fwdB;
   state_t     r_state;
   state_t     w_nextState;

   // EX slot doubles as the ex_* outputs. MEM keeps its destination for
   // forwarding; WB only matters for drain, since a WB producer is read
   // through the register file's write-then-read behaviour.
   logic       r_exValid;
   logic [5:0] r_exOpcode;
   logic [4:0] r_exDest;
   logic       r_exIsLoad;
   fwdSel_t    r_fwdASel;
   fwdSel_t    r_fwdBSel;
   logic       r_memValid;
   logic [4:0] r_memDest;
   logic       r_wbValid;

   op_class_decode u_opClassDecode (
      .i_opcode (i_idOpcode),
      .o_class  (w_cls)
   );

   // Select the destination field of the ID instruction; none tracks as r0.
   always_comb begin
      w_idDest = 5'd0;
      case (w_cls.destSel)
         DEST_RT: w_idDest = i_idRt;
         DEST_RD: w_idDest = i_idRd;
         default: w_idDest = 5'd0;
      endcase
   end

   assign w_rsHitLoad = w_cls.usesRs && (i_idRs != 5'd0) && (i_idRs == r_exDest);
   assign w_rtHitLoad = w_cls.usesRt && (i_idRt != 5'd0) && (i_idRt == r_exDest);
   assign w_loadUse   = i_idValid && r_exValid && r_exIsLoad && (w_rsHitLoad || w_rtHitLoad);

   assign w_issue = i_idValid && i_exReady && (r_state == RUN) && !w_loadUse && !i_flush;

   assign w_fwdA = fwdSelect(w_cls.usesRs, i_idRs, r_exValid, r_exDest, r_memValid, r_memDest);
   assign w_fwdB = fwdSelect(w_cls.usesRt, i_idRt, r_exValid, r_exDest, r_memValid, r_memDest);

   assign o_idStall = !i_rst && (w_loadUse || !i_exReady || ((r_state != RUN) && i_idValid));

   // Advance the EX/MEM/WB tracking slots when EX moves; a bubble enters
   // EX whenever the ID instruction is not issued.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_exValid  <= 1'b0;
         r_exOpcode <= 6'd0;
         r_exDest   <= 5'd0;
         r_exIsLoad <= 1'b0;
         r_fwdASel  <= FWD_RF;
         r_fwdBSel  <= FWD_RF;
         r_memValid <= 1'b0;
         r_memDest  <= 5'd0;
         r_wbValid  <= 1'b0;
      end else if (i_exReady) begin
         r_wbValid  <= r_memValid;
         r_memValid <= r_exValid;
         r_memDest  <= r_exDest;
         if (w_issue) begin
            r_exValid  <= 1'b1;
            r_exOpcode <= i_idOpcode;
            r_exDest   <= w_idDest;
            r_exIsLoad <= w_cls.isLoad;
            r_fwdASel  <= w_fwdA;
            r_fwdBSel  <= w_fwdB;
         end else begin
            r_exValid  <= 1'b0;
            r_exOpcode <= 6'd0;
            r_exDest   <= 5'd0;
            r_exIsLoad <= 1'b0;
            r_fwdASel  <= FWD_RF;
            r_fwdBSel  <= FWD_RF;
         end
      end
   end

   // Controller state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: an issued HLT starts the drain; halted is reached on the
   // very edge that empties WB, i.e. when EX and MEM are already empty.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         RUN: begin
            if (w_issue && w_cls.isHalt) begin
               w_nextState = DRAIN;
            end
         end
         DRAIN: begin
            if (!r_exValid && !r_memValid && (i_exReady || !r_wbValid)) begin
               w_nextState = HALTED;
            end
         end
         HALTED: w_nextState = HALTED;
         default: w_nextState = RUN;
      endcase
   end

   assign o_exValid  = r_exValid;
   assign o_exOpcode = r_exOpcode;
   assign o_exDest   = r_exDest;
   assign o_fwdASel  = r_fwdASel;
   assign o_fwdBSel  = r_fwdBSel;
   assign o_halted   = (r_state == HALTED);

endmodule
